// File: rtl/pipe_dest_ctrl_if.sv
// Destination-info bundle between the ID stage, this controller and the forwarding unit.
// master drives the ID-side requests; slave (pipe_dest_ctrl) returns stage info, stall and the counter.
interface pipe_dest_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       id_rn;
  logic             id_wreg;
  logic             id_m2reg;
  logic             flush_id;
  logic             flush_exe;
  logic             mem_ready;

  logic [4:0]       exe_rn;
  logic             exe_wreg;
  logic             exe_m2reg;
  logic [4:0]       mem_rn;
  logic             mem_wreg;
  logic             mem_m2reg;
  logic [4:0]       wb_rn;
  logic             wb_wreg;
  logic             stall;
  logic [CNT_W-1:0] lu_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_rn, id_wreg, id_m2reg,
           flush_id, flush_exe, mem_ready,
    input  exe_rn, exe_wreg, exe_m2reg, mem_rn, mem_wreg, mem_m2reg,
           wb_rn, wb_wreg, stall, lu_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_rn, id_wreg, id_m2reg,
           flush_id, flush_exe, mem_ready,
    output exe_rn, exe_wreg, exe_m2reg, mem_rn, mem_wreg, mem_m2reg,
           wb_rn, wb_wreg, stall, lu_cnt
  );
endinterface

// File: rtl/pipe_dest_ctrl.sv
// Carries destination-register info ID->EXE->MEM->WB for forwarding; 1 cycle per stage.
// Load-use hazards bubble EXE and stall IF/ID; mem_ready=0 freezes every stage and the counter.
module pipe_dest_ctrl #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             clrn,
  pipe_dest_ctrl_if.slave pif
);

  typedef struct packed {
    logic [4:0] rn;
    logic       wreg;
    logic       m2reg;
  } dest_t;

  localparam dest_t BUBBLE = '{rn: 5'd0, wreg: 1'b0, m2reg: 1'b0};

  dest_t            id_d;
  dest_t            exe_q;
  dest_t            mem_q;
  dest_t            wb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rs_dep;
  logic             rt_dep;
  logic             hazard;
  logic             exe_load;
  logic             cnt_inc;
  logic             exe_kill;

  assign id_d = '{rn: pif.id_rn, wreg: pif.id_wreg, m2reg: pif.id_m2reg};

  // A load to r0 never produces a usable value, so it cannot create a dependency.
  assign exe_load = exe_q.wreg & exe_q.m2reg & (exe_q.rn != 5'd0);
  assign rs_dep   = pif.id_use_rs & (pif.id_rs == exe_q.rn);
  assign rt_dep   = pif.id_use_rt & (pif.id_rt == exe_q.rn);
  assign hazard   = exe_load & (rs_dep | rt_dep);

  // A flushed ID instruction is discarded, so its hazard neither stalls nor counts.
  assign pif.stall = ~pif.mem_ready | (hazard & ~pif.flush_id);
  assign cnt_inc   = hazard & ~pif.flush_id & ~(&cnt_q);
  assign exe_kill  = pif.flush_id | pif.flush_exe | hazard;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      exe_q <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
      cnt_q <= '0;
    end else if (pif.mem_ready) begin
      wb_q  <= mem_q;
      mem_q <= pif.flush_exe ? BUBBLE : exe_q;
      exe_q <= exe_kill ? BUBBLE : id_d;
      if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pif.exe_rn    = exe_q.rn;
  assign pif.exe_wreg  = exe_q.wreg;
  assign pif.exe_m2reg = exe_q.m2reg;
  assign pif.mem_rn    = mem_q.rn;
  assign pif.mem_wreg  = mem_q.wreg;
  assign pif.mem_m2reg = mem_q.m2reg;
  assign pif.wb_rn     = wb_q.rn;
  assign pif.wb_wreg   = wb_q.wreg;
  assign pif.lu_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_dest_ctrl.sv
// Directed scenarios plus randomized traffic against a queue-style model of the three pipeline slots.
module tb_pipe_dest_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  pipe_dest_ctrl_if #(.CNT_W(CNT_W)) pif ();

  pipe_dest_ctrl #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .pif  (pif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rn;
    int wreg;
    int m2reg;
  } slot_t;

  // Pipeline contents: index 0 = EXE, 1 = MEM, 2 = WB.
  slot_t m_pipe[3];
  int    m_cnt;
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.rn = 0; s.wreg = 0; s.m2reg = 0;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = empty_slot();
    m_cnt = 0;
  endtask

  function automatic bit m_hazard();
    bit reads_it;
    if (m_pipe[0].wreg == 0 || m_pipe[0].m2reg == 0 || m_pipe[0].rn == 0) return 1'b0;
    reads_it = (pif.id_use_rs && int'(pif.id_rs) == m_pipe[0].rn) ||
               (pif.id_use_rt && int'(pif.id_rt) == m_pipe[0].rn);
    return reads_it;
  endfunction

  function automatic bit m_stall();
    return !pif.mem_ready || (m_hazard() && !pif.flush_id);
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, ".exe_rn"},    32'(pif.exe_rn),    32'(m_pipe[0].rn));
    chk({tag, ".exe_wreg"},  32'(pif.exe_wreg),  32'(m_pipe[0].wreg));
    chk({tag, ".exe_m2reg"}, 32'(pif.exe_m2reg), 32'(m_pipe[0].m2reg));
    chk({tag, ".mem_rn"},    32'(pif.mem_rn),    32'(m_pipe[1].rn));
    chk({tag, ".mem_wreg"},  32'(pif.mem_wreg),  32'(m_pipe[1].wreg));
    chk({tag, ".mem_m2reg"}, 32'(pif.mem_m2reg), 32'(m_pipe[1].m2reg));
    chk({tag, ".wb_rn"},     32'(pif.wb_rn),     32'(m_pipe[2].rn));
    chk({tag, ".wb_wreg"},   32'(pif.wb_wreg),   32'(m_pipe[2].wreg));
    chk({tag, ".lu_cnt"},    32'(pif.lu_cnt),    32'(m_cnt));
  endtask

  // One clock: check stall mid-cycle, advance the model by the pipeline rules, check registers after the edge.
  task automatic step(input string tag);
    slot_t incoming;
    bit    hz;
    #1;
    hz = m_hazard();
    chk({tag, ".stall"}, 32'(pif.stall), 32'(m_stall()));
    incoming.rn = int'(pif.id_rn); incoming.wreg = int'(pif.id_wreg); incoming.m2reg = int'(pif.id_m2reg);
    @(posedge clk);
    if (pif.mem_ready) begin
      if (hz && !pif.flush_id && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = pif.flush_exe ? empty_slot() : m_pipe[0];
      m_pipe[0] = (pif.flush_id || pif.flush_exe || hz) ? empty_slot() : incoming;
    end
    #1;
    chk_outputs(tag);
  endtask

  task automatic set_id(input int rs, input int urs, input int rt, input int urt,
                        input int rn, input int wreg, input int m2reg);
    pif.id_rs = 5'(rs);  pif.id_use_rs = urs[0];
    pif.id_rt = 5'(rt);  pif.id_use_rt = urt[0];
    pif.id_rn = 5'(rn);  pif.id_wreg = wreg[0]; pif.id_m2reg = m2reg[0];
    pif.flush_id = 1'b0; pif.flush_exe = 1'b0; pif.mem_ready = 1'b1;
  endtask

  task automatic randomize_inputs();
    pif.id_rs     = 5'($urandom_range(0, 3));
    pif.id_rt     = 5'($urandom_range(0, 3));
    pif.id_use_rs = 1'($urandom);
    pif.id_use_rt = 1'($urandom);
    pif.id_rn     = 5'($urandom_range(0, 3));
    pif.id_wreg   = 1'($urandom);
    pif.id_m2reg  = 1'($urandom);
    pif.flush_id  = ($urandom_range(0, 9) == 0);
    pif.flush_exe = ($urandom_range(0, 9) == 0);
    pif.mem_ready = ($urandom_range(0, 4) != 0);
  endtask

  int cnt_before;

  initial begin
    // Reset with random inputs.
    model_reset();
    randomize_inputs();
    #3;
    chk_outputs("rst");
    chk("rst.stall", 32'(pif.stall), 32'(!pif.mem_ready));

    // Release and follow one instruction through the stages.
    @(negedge clk);
    clrn = 1'b1;
    set_id(0, 0, 0, 0, 5, 1, 0);
    step("lat1");
    chk("lat1.exe_rn_is5", 32'(pif.exe_rn), 32'd5);
    set_id(0, 0, 0, 0, 0, 0, 0);
    step("lat2");
    chk("lat2.mem_rn_is5", 32'(pif.mem_rn), 32'd5);
    step("lat3");
    chk("lat3.wb_rn_is5", 32'(pif.wb_rn), 32'd5);
    chk("lat3.wb_wreg", 32'(pif.wb_wreg), 32'd1);

    // Load-use on rs.
    set_id(0, 0, 0, 0, 8, 1, 1);
    step("lu_load");
    set_id(8, 1, 0, 0, 3, 1, 0);
    #1;
    chk("lu.stall_hi", 32'(pif.stall), 32'd1);
    step("lu_bubble");
    chk("lu.exe_wreg_bubble", 32'(pif.exe_wreg), 32'd0);
    chk("lu.cnt_is1", 32'(pif.lu_cnt), 32'd1);
    #1;
    chk("lu.stall_lo", 32'(pif.stall), 32'd0);
    step("lu_enter");
    chk("lu.exe_rn_is3", 32'(pif.exe_rn), 32'd3);

    // No false hazards.
    set_id(0, 0, 0, 0, 0, 1, 1);
    step("nf_r0_load");
    set_id(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("nf.r0_stall", 32'(pif.stall), 32'd0);
    step("nf_r0");
    set_id(0, 0, 0, 0, 8, 1, 1);
    step("nf_r8_load");
    set_id(0, 0, 8, 0, 0, 0, 0);
    #1;
    chk("nf.unused_rt_stall", 32'(pif.stall), 32'd0);
    step("nf_rt");
    set_id(0, 0, 0, 0, 8, 1, 0);
    step("nf_alu");
    set_id(8, 1, 8, 1, 0, 0, 0);
    #1;
    chk("nf.alu_stall", 32'(pif.stall), 32'd0);
    step("nf_alu_use");

    // flush_id together with a hazard.
    set_id(0, 0, 0, 0, 8, 1, 1);
    step("fid_load");
    cnt_before = m_cnt;
    set_id(8, 1, 0, 0, 6, 1, 0);
    pif.flush_id = 1'b1;
    #1;
    chk("fid.stall", 32'(pif.stall), 32'd0);
    step("fid");
    chk("fid.exe_wreg", 32'(pif.exe_wreg), 32'd0);
    chk("fid.cnt_same", 32'(pif.lu_cnt), 32'(cnt_before));

    // flush_exe kills both the EXE instruction and the one entering EXE.
    set_id(0, 0, 0, 0, 9, 1, 0);
    step("fexe_load");
    set_id(0, 0, 0, 0, 4, 1, 0);
    pif.flush_exe = 1'b1;
    step("fexe");
    chk("fexe.mem_wreg", 32'(pif.mem_wreg), 32'd0);
    chk("fexe.mem_rn", 32'(pif.mem_rn), 32'd0);
    chk("fexe.exe_wreg", 32'(pif.exe_wreg), 32'd0);

    // Memory wait for 3 cycles mid-stream, with a pending hazard and flushes that must be ignored.
    set_id(0, 0, 0, 0, 7, 1, 1);
    step("mw_fill1");
    set_id(7, 1, 0, 0, 2, 1, 0);
    pif.mem_ready = 1'b0;
    pif.flush_exe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw.stall_hi", 32'(pif.stall), 32'd1);
      step("mw_hold");
      chk("mw.exe_rn_held", 32'(pif.exe_rn), 32'd7);
    end
    pif.flush_exe = 1'b0;
    pif.mem_ready = 1'b1;
    step("mw_resume");
    chk("mw.mem_rn_adv", 32'(pif.mem_rn), 32'd7);

    // Counter saturation: drive more than 2^CNT_W load-use pairs.
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      set_id(0, 0, 0, 0, 8, 1, 1);
      step("sat_load");
      set_id(0, 0, 8, 1, 0, 0, 0);
      step("sat_use");
      step("sat_enter");
    end
    chk("sat.cnt_max", 32'(pif.lu_cnt), 32'(CNT_MAX));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rnd");
    end

    // Asynchronous reset mid-operation, then normal loading from the first edge after release.
    #2;
    clrn = 1'b0;
    model_reset();
    #1;
    chk_outputs("rst2");
    @(negedge clk);
    clrn = 1'b1;
    set_id(0, 0, 0, 0, 12, 1, 1);
    step("rst2_first");
    chk("rst2.exe_rn", 32'(pif.exe_rn), 32'd12);
    for (int i = 0; i < 50; i++) begin
      randomize_inputs();
      step("rnd2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_dest_ctrl.md
# pipe_dest_ctrl

Producer side of the pipeline forwarding path. The block carries each instruction's destination-register information from ID through the EXE, MEM and WB pipeline registers, and supplies the `exe_*`/`mem_*` signals that the operand-forwarding unit consumes. It also detects load-use hazards, inserts bubbles, and applies interrupt/exception flushes and memory wait-holds. It sits beside the ID stage of the five-stage interrupt-capable pipelined CPU.

## Interface
- `CNT_W`, 16, width of the load-use stall event counter
- `clk` in 1: pipeline clock, all state updates on the rising edge
- `clrn` in 1: asynchronous active-low reset
- `id_rs`, `id_rt` in 5: source register numbers of the ID instruction
- `id_use_rs`, `id_use_rt` in 1: ID instruction actually reads rs / rt
- `id_rn` in 5: destination register number of the ID instruction
- `id_wreg`, `id_m2reg` in 1: ID instruction writes the register file / the result comes from memory
- `flush_id` in 1: kill the ID instruction (interrupt or branch redirect)
- `flush_exe` in 1: kill the EXE instruction (exception raised in EXE)
- `mem_ready` in 1: data memory can complete this cycle; 0 freezes the whole pipeline
- `exe_rn` out 5, `exe_wreg` out 1, `exe_m2reg` out 1: EXE-stage destination info
- `mem_rn` out 5, `mem_wreg` out 1, `mem_m2reg` out 1: MEM-stage destination info
- `wb_rn` out 5, `wb_wreg` out 1: WB-stage destination info
- `stall` out 1: holds PC and the IF/ID register (combinational)
- `lu_cnt` out CNT_W: saturating count of load-use stall cycles

## Operation
- `hazard` = `exe_wreg & exe_m2reg & (exe_rn != 0) & ((id_use_rs & id_rs == exe_rn) | (id_use_rt & id_rt == exe_rn))`.
- Bubble = `rn = 0`, `wreg = 0`, `m2reg = 0`.
- `stall` = `~mem_ready | (hazard & ~flush_id)`.
- Priority at each clock edge, highest first:
  1. `mem_ready = 0`: all stage registers hold and `lu_cnt` holds. Flushes are ignored this cycle; the flush source must hold its request until `mem_ready` is 1.
  2. Otherwise WB ← MEM, and MEM ← EXE, or a bubble if `flush_exe`.
  3. EXE ← ID fields, or a bubble if `flush_id | flush_exe | hazard`.
- `flush_id` with `hazard` in the same cycle: a bubble is inserted, `stall` = 0 (the ID instruction is discarded and the PC is redirected), and `lu_cnt` is not incremented.
- `flush_exe` also bubbles the ID→EXE transfer, because a younger instruction behind an exception is never kept.
- `lu_cnt` increments by 1 on each edge where `mem_ready & hazard & ~flush_id`. It saturates at all ones and never wraps.
- `id_rn = 0` with `id_wreg = 1` propagates unchanged. Filtering out r0 is the consumer's job.

## Timing
- Reset (`clrn` low, asynchronous): every output register is 0, i.e. all stages hold bubbles and `lu_cnt` = 0. `stall` is then `~mem_ready`.
- Reset deassertion mid-operation: the first edge after release loads ID normally. Instructions in flight before reset are lost by design.
- Latency: an ID instruction appears on the `exe_*` outputs 1 cycle later, on `mem_*` 2 cycles later and on `wb_*` 3 cycles later, with no stalls or holds.
- Load-use stall: `stall` is high for exactly 1 cycle per dependent load (a bubble lands in EXE, so `hazard` drops the next cycle). This stretches to more cycles only when `mem_ready` is low.
- `stall` is purely combinational from the current registers and inputs, with no added register delay.

## Test plan
- **Reset:** `clrn`=0 with random inputs → all stage outputs and `lu_cnt` = 0; release and drive ID `rn=5, wreg=1, m2reg=0` → `exe_rn`=5 on edge 1, `mem_rn`=5 on edge 2, `wb_rn`=5 on edge 3.
- **Load-use:** EXE holds `rn=8, wreg=1, m2reg=1`; ID has `rs=8, use_rs=1` → `stall`=1 for 1 cycle, the next `exe_wreg`=0, `lu_cnt`=1; the following cycle `stall`=0 and the ID instruction enters EXE.
- **No false hazard:**
  - EXE load to r0 with ID `rs=0` → `stall`=0.
  - EXE load to r8 with ID `rt=8, use_rt=0` → `stall`=0.
  - EXE non-load to r8 → `stall`=0.
- **Flush:**
  - `flush_id`=1 together with a hazard → `stall`=0, EXE receives a bubble, `lu_cnt` unchanged.
  - `flush_exe`=1 with EXE `rn=9, wreg=1` → next `mem_wreg`=0, `mem_rn`=0, and EXE is also a bubble.
- **Memory wait:** `mem_ready`=0 for 3 cycles mid-stream → all stage outputs frozen, `stall`=1 throughout, `lu_cnt` frozen; normal advance resumes on the first edge with `mem_ready`=1.
- **Counter saturation:** preload by forcing `CNT_W`=4 and 16 consecutive hazards → `lu_cnt` reaches 15 and stays at 15.
